// File: rtl/unaligned_load_align_ctrl.sv
// -----------------------------------------------------------------------------
// unaligned_load_align_ctrl
//
// Purpose:
//   Sequences one unaligned load at a time against a line-granular cache read
//   port. A load whose bytes fit in one line costs one line read. A load that
//   crosses a line boundary costs two line reads: the line holding the first
//   byte, then the next line. Each returned line goes through one shared byte
//   rotator, so the first requested byte lands at byte 0. The two rotated lines
//   are merged, bytes beyond the requested size are zeroed, and the result is
//   presented on a valid/ready output.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_*           load request: valid/ready, byte address, size (0 = full line)
//   mem_req_*       line read request: valid/ready, line-aligned address
//   mem_rsp_*       line read response: one-cycle valid pulse plus line data
//   out_*           aligned result: valid/ready, data, flag for a two-line access
//   split_cnt       count of completed two-line loads (optional feature)
//
// Optional feature:
//   Define ALIGN_CTRL_PERF_EN to build a saturating 16-bit counter of completed
//   split loads. Without the macro, split_cnt is tied to zero and no counter
//   flops are built.
// -----------------------------------------------------------------------------
module unaligned_load_align_ctrl #(
  parameter int NUM_BYTES = 16,
  parameter int ADDR_W    = 32,
  parameter int AMT_W     = $clog2(NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [AMT_W:0]         req_size,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [NUM_BYTES*8-1:0] mem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] out_data,
  output logic                   out_split,
  output logic [15:0]            split_cnt
);

  localparam int DW = NUM_BYTES * 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_MERGE = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  localparam logic [AMT_W:0]   NB_SZ = (AMT_W+1)'(NUM_BYTES);
  localparam logic [AMT_W+1:0] NB_W2 = (AMT_W+2)'(NUM_BYTES);

  logic [2:0]        state_reg, state_next;
  logic [AMT_W-1:0]  off_reg;
  logic [AMT_W:0]    sz_reg;
  logic              split_reg;
  logic [ADDR_W-1:0] line0_reg, line1_reg;
  logic [DW-1:0]     buf0_reg, buf1_reg;
  logic [DW-1:0]     out_data_reg;
  logic              out_split_reg;

  logic              accept;
  logic              out_fire;
  logic [AMT_W-1:0]  req_off;
  logic [AMT_W:0]    req_sz;
  logic              req_split;
  logic [ADDR_W-1:0] req_line0;
  logic [AMT_W-1:0]  amt;
  logic [DW-1:0]     rot_data;
  logic [DW-1:0]     merged;

  assign accept    = req_valid && req_ready;
  assign out_fire  = out_valid && out_ready;

  // Request decode: byte offset in the line, normalized size and whether the
  // last byte falls into the following line. The sum is formed one bit wider
  // than the size so a full-size load at the last offset cannot overflow.
  assign req_off   = req_addr[AMT_W-1:0];
  assign req_sz    = (req_size == '0) ? NB_SZ : req_size;
  assign req_split = ({2'b00, req_off} + {1'b0, req_sz}) > NB_W2;
  assign req_line0 = {req_addr[ADDR_W-1:AMT_W], {AMT_W{1'b0}}};

  // Rotating left by (NUM_BYTES - off) mod NUM_BYTES moves the byte at the
  // offset to byte 0. Both line responses use the same amount.
  assign amt = '0 - off_reg;

  // Shared rotator: out byte i = in byte (i - amt) mod NUM_BYTES.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_rot
    logic [AMT_W-1:0] src;
    assign src = AMT_W'(gi) - amt;
    assign rot_data[gi*8 +: 8] = mem_rsp_data[{src, 3'b000} +: 8];
  end

  // Merge: the first NUM_BYTES-off result bytes come from the first line and
  // the rest from the second. Bytes at or beyond the size read as zero.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
    logic take_first;
    logic keep;
    assign take_first = !split_reg ||
                        ((AMT_W+1)'(gi) < (NB_SZ - {1'b0, off_reg}));
    assign keep       = (AMT_W+1)'(gi) < sz_reg;
    assign merged[gi*8 +: 8] = !keep      ? 8'h00 :
                               take_first ? buf0_reg[gi*8 +: 8] :
                                            buf1_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept)        state_next = S_REQ0;
      S_REQ0:  if (mem_req_ready) state_next = S_WAIT0;
      S_WAIT0: if (mem_rsp_valid) state_next = split_reg ? S_REQ1 : S_MERGE;
      S_REQ1:  if (mem_req_ready) state_next = S_WAIT1;
      S_WAIT1: if (mem_rsp_valid) state_next = S_MERGE;
      S_MERGE:                    state_next = S_OUT;
      S_OUT:   if (out_fire)      state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      off_reg       <= '0;
      sz_reg        <= '0;
      split_reg     <= 1'b0;
      line0_reg     <= '0;
      line1_reg     <= '0;
      buf0_reg      <= '0;
      buf1_reg      <= '0;
      out_data_reg  <= '0;
      out_split_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        off_reg   <= req_off;
        sz_reg    <= req_sz;
        split_reg <= req_split;
        line0_reg <= req_line0;
        line1_reg <= req_line0 + ADDR_W'(NUM_BYTES);
      end
      if (state_reg == S_WAIT0 && mem_rsp_valid) begin
        buf0_reg <= rot_data;
      end
      if (state_reg == S_WAIT1 && mem_rsp_valid) begin
        buf1_reg <= rot_data;
      end
      if (state_reg == S_MERGE) begin
        out_data_reg  <= merged;
        out_split_reg <= split_reg;
      end else if (out_fire) begin
        out_split_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_req_addr = '0;
    case (state_reg)
      S_REQ0:  mem_req_addr = line0_reg;
      S_REQ1:  mem_req_addr = line1_reg;
      default: mem_req_addr = '0;
    endcase
  end

  assign req_ready     = (state_reg == S_IDLE);
  assign mem_req_valid = (state_reg == S_REQ0) || (state_reg == S_REQ1);
  assign out_valid     = (state_reg == S_OUT);
  assign out_data      = out_data_reg;
  assign out_split     = out_split_reg;

`ifdef ALIGN_CTRL_PERF_EN
  logic [15:0] split_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_cnt_reg <= '0;
    end else if (out_fire && out_split_reg && split_cnt_reg != 16'hFFFF) begin
      split_cnt_reg <= split_cnt_reg + 16'd1;
    end
  end

  assign split_cnt = split_cnt_reg;
`else
  assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_unaligned_load_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_unaligned_load_align_ctrl
//
// Bench for unaligned_load_align_ctrl with NUM_BYTES=16, ADDR_W=32. The
// expected data comes from a flat byte-addressed memory model: the byte at
// address b is (b mod 256) ^ seed, and line reads return slices of the same
// memory. A load of size sz at addr must therefore yield bytes
// mem[addr+i] for i < sz and zero elsewhere. The expected read addresses come
// from the line containing addr and the line after it.
// Build with ALIGN_CTRL_PERF_EN defined to check the split counter.
// -----------------------------------------------------------------------------
module tb_unaligned_load_align_ctrl;

  localparam int NB = 16;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [4:0]   req_size;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_split;
  logic [15:0]  split_cnt;

  int           checks;
  int           failures;
  int           cyc;
  logic [7:0]   seed;
  int           exp_split_cnt;

  unaligned_load_align_ctrl #(.NUM_BYTES(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_split(out_split),
    .split_cnt(split_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ seed;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] line_addr);
    logic [127:0] d;
    for (int k = 0; k < NB; k++) d[k*8 +: 8] = mem_byte(line_addr + 32'(k));
    return d;
  endfunction

  function automatic logic [15:0] exp_cnt_value();
`ifdef ALIGN_CTRL_PERF_EN
    return 16'(exp_split_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // One complete load. Entered and left just after a falling edge.
  task automatic run_load(input logic [31:0] addr, input logic [4:0] size,
                          input int stall_req, input int rsp_dly,
                          input int stall_out, input bit chain,
                          output int lat);
    int           sz;
    int           off;
    int           nreads;
    int           acc;
    int           n;
    bit           exp_split;
    logic [31:0]  lines [2];
    logic [127:0] exp_data;
    logic [31:0]  bi;
    lat       = -1;
    sz        = (size == 0) ? NB : int'(size);
    off       = int'(addr[3:0]);
    exp_split = (off + sz) > NB;
    nreads    = exp_split ? 2 : 1;
    lines[0]  = {addr[31:4], 4'h0};
    lines[1]  = lines[0] + 32'd16;
    for (int i = 0; i < NB; i++) begin
      bi = addr + 32'(i);
      exp_data[i*8 +: 8] = (i < sz) ? mem_byte(bi) : 8'h00;
    end

    req_valid = 1'b1;
    req_addr  = addr;
    req_size  = size;
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL req_ready_idle addr=%h got=%b want=1", addr, req_ready);
      failures++;
    end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    for (int r = 0; r < nreads; r++) begin
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 20) begin
        $display("FAIL mem_req_timeout addr=%h read=%0d got=no request want=request", addr, r);
        failures++;
        return;
      end
      checks++;
      if (mem_req_addr !== lines[r]) begin
        $display("FAIL mem_req_addr addr=%h read=%0d got=%h want=%h", addr, r, mem_req_addr, lines[r]);
        failures++;
      end
      if (r == 0) begin
        for (int s = 0; s < stall_req; s++) begin
          checks++;
          if (mem_req_valid !== 1'b1 || mem_req_addr !== lines[0] || req_ready !== 1'b0) begin
            $display("FAIL req_stall_hold cycle=%0d got=v%b a=%h rr%b want=v1 a=%h rr0",
                     s, mem_req_valid, mem_req_addr, req_ready, lines[0]);
            failures++;
          end
          @(negedge clk);
        end
      end
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b0) begin
        $display("FAIL mem_req_drop addr=%h read=%0d got=%b want=0", addr, r, mem_req_valid);
        failures++;
      end
      repeat (rsp_dly) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_of(lines[r]);
      @(posedge clk);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
    end

    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      $display("FAIL out_valid_timeout addr=%h got=no result want=result", addr);
      failures++;
      return;
    end
    lat = cyc - acc;

    checks++;
    if (out_data !== exp_data) begin
      $display("FAIL out_data addr=%h size=%0d got=%h want=%h", addr, sz, out_data, exp_data);
      failures++;
    end
    checks++;
    if (out_split !== exp_split) begin
      $display("FAIL out_split addr=%h size=%0d got=%b want=%b", addr, sz, out_split, exp_split);
      failures++;
    end
    for (int s = 0; s < stall_out; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data || req_ready !== 1'b0) begin
        $display("FAIL out_stall_hold cycle=%0d got=v%b d=%h rr%b want=v1 d=%h rr0",
                 s, out_valid, out_data, req_ready, exp_data);
        failures++;
      end
    end

    out_ready = 1'b1;
    if (chain) begin
      req_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_split) exp_split_cnt++;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      $display("FAIL after_handshake addr=%h got=ov%b rr%b mv%b want=ov0 rr1 mv0",
               addr, out_valid, req_ready, mem_req_valid);
      failures++;
    end
    checks++;
    if (split_cnt !== exp_cnt_value()) begin
      $display("FAIL split_cnt addr=%h got=%0d want=%0d", addr, split_cnt, exp_cnt_value());
      failures++;
    end
    $display("load addr=%h size=%0d split=%0b lat=%0d", addr, sz, exp_split, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
        out_valid !== 1'b0 || out_data !== 128'h0 || out_split !== 1'b0 || split_cnt !== 16'h0) begin
      $display("FAIL reset_values got=rr%b mv%b ma%h ov%b od%h os%b sc%h want=rr1 all others 0",
               req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_split, split_cnt);
      failures++;
    end
    rst = 1'b0;
    exp_split_cnt = 0;
    @(negedge clk);
    $display("reset check done");
  endtask

  task automatic test_directed();
    int lat;
    seed = 8'h00;
    run_load(32'h0000_0100, 5'd16, 0, 0, 0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      $display("FAIL latency_nonsplit got=%0d want=4", lat);
      failures++;
    end
    run_load(32'h0000_0105, 5'd4, 0, 0, 0, 1'b0, lat);
    run_load(32'h0000_010E, 5'd8, 0, 0, 0, 1'b0, lat);
    checks++;
    if (lat !== 6) begin
      $display("FAIL latency_split got=%0d want=6", lat);
      failures++;
    end
    run_load(32'hFFFF_FFF8, 5'd16, 0, 0, 0, 1'b0, lat);
    run_load(32'h0000_0230, 5'd0, 0, 0, 0, 1'b0, lat);
    run_load(32'h0000_023F, 5'd1, 0, 0, 0, 1'b0, lat);
  endtask

  task automatic test_stall();
    int lat;
    seed = 8'h5A;
    run_load(32'h0000_0344, 5'd7, 5, 2, 3, 1'b0, lat);
    run_load(32'h0000_034C, 5'd12, 5, 1, 3, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    seed = 8'hC3;
    run_load(32'h0000_0409, 5'd10, 0, 0, 0, 1'b1, lat);
    run_load(32'h0000_0402, 5'd3, 0, 0, 0, 1'b1, lat);
    run_load(32'h0000_0400, 5'd16, 0, 0, 0, 1'b0, lat);
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 40; t++) begin
      seed = 8'($urandom);
      run_load($urandom, 5'($urandom_range(0, 16)), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    seed = 8'h11;
    req_valid = 1'b1;
    req_addr  = 32'h0000_050E;
    req_size  = 5'd8;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (r == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_of(32'h0000_0500);
        @(posedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
    end
    // Now waiting for the second line.
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
        out_valid !== 1'b0 || out_data !== 128'h0 || out_split !== 1'b0 || split_cnt !== 16'h0) begin
      $display("FAIL reset_mid got=rr%b mv%b ma%h ov%b od%h os%b sc%h want=rr1 all others 0",
               req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_split, split_cnt);
      failures++;
    end
    exp_split_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    // A late response after reset must be ignored.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_of(32'h0000_0510);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      $display("FAIL stale_rsp_ignored got=rr%b ov%b mv%b want=rr1 ov0 mv0",
               req_ready, out_valid, mem_req_valid);
      failures++;
    end
    $display("reset mid-operation check done");
  endtask

  task automatic test_split_cnt();
    int lat;
    seed = 8'h77;
    run_load(32'h0000_060A, 5'd9, 0, 0, 0, 1'b0, lat);
    run_load(32'h0000_061F, 5'd2, 1, 1, 1, 1'b0, lat);
    run_load(32'h0000_0621, 5'd16, 0, 0, 0, 1'b0, lat);
    checks++;
    if (split_cnt !== exp_cnt_value()) begin
      $display("FAIL split_cnt_three got=%0d want=%0d", split_cnt, exp_cnt_value());
      failures++;
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_split_cnt = 0;
    seed          = 8'h00;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_size      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    out_ready     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_split_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
